// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Shared constants and types for the Y86-64 pipeline control
//               unit: instruction codes, stage status codes, register "none"
//               encoding and the run/halt state enumeration.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Y86-64 instruction codes
    localparam logic [3:0] c_I_HALT   = 4'h0;
    localparam logic [3:0] c_I_NOP    = 4'h1;
    localparam logic [3:0] c_I_RRMOVQ = 4'h2;
    localparam logic [3:0] c_I_IRMOVQ = 4'h3;
    localparam logic [3:0] c_I_RMMOVQ = 4'h4;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_CALL   = 4'h8;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_PUSHQ  = 4'hA;
    localparam logic [3:0] c_I_POPQ   = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] c_RNONE    = 4'hF;

    // Stage status codes
    localparam logic [2:0] c_STAT_AOK = 3'd1;
    localparam logic [2:0] c_STAT_HLT = 3'd2;
    localparam logic [2:0] c_STAT_ADR = 3'd3;
    localparam logic [2:0] c_STAT_INS = 3'd4;

    // Run/halt controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Purely combinational hazard detection for the five-stage
//               Y86-64 pipeline. Derives the load/use, ret-in-flight and
//               mispredict terms and the stage stall/bubble controls that
//               apply while the core is running.
// Ports       : i_D_icode, i_d_srcA, i_d_srcB  - decode stage view
//               i_E_icode, i_E_dstM, i_e_Cnd   - execute stage view
//               i_M_icode, i_m_stat            - memory stage view
//               i_W_stat                       - write-back status
//               o_loaduse, o_retp, o_misp      - raw hazard terms
//               o_exc_m, o_exc_w               - exception status flags
//               o_*_stall / o_*_bubble         - run-mode stage controls
// Revision    : 1.0  initial release
// ============================================================================
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int STAT_W = 3
) (
    input  logic [3:0]        i_D_icode,
    input  logic [3:0]        i_d_srcA,
    input  logic [3:0]        i_d_srcB,
    input  logic [3:0]        i_E_icode,
    input  logic [3:0]        i_E_dstM,
    input  logic              i_e_Cnd,
    input  logic [3:0]        i_M_icode,
    input  logic [STAT_W-1:0] i_m_stat,
    input  logic [STAT_W-1:0] i_W_stat,
    output logic              o_loaduse,
    output logic              o_retp,
    output logic              o_misp,
    output logic              o_exc_m,
    output logic              o_exc_w,
    output logic              o_F_stall,
    output logic              o_D_stall,
    output logic              o_W_stall,
    output logic              o_D_bubble,
    output logic              o_E_bubble,
    output logic              o_M_bubble
);

    function automatic logic f_exc(input logic [STAT_W-1:0] s);
        return (s == STAT_W'(c_STAT_HLT)) ||
               (s == STAT_W'(c_STAT_ADR)) ||
               (s == STAT_W'(c_STAT_INS));
    endfunction

    logic w_e_is_load;

    always_comb begin
        w_e_is_load = (i_E_icode == c_I_MRMOVQ) || (i_E_icode == c_I_POPQ);

        // A load whose destination is "none" cannot feed decode, even if a
        // decode source also reads as "none".
        o_loaduse   = w_e_is_load && (i_E_dstM != c_RNONE) &&
                      ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));

        o_retp      = (i_D_icode == c_I_RET) || (i_E_icode == c_I_RET) ||
                      (i_M_icode == c_I_RET);
        o_misp      = (i_E_icode == c_I_JXX) && !i_e_Cnd;
        o_exc_m     = f_exc(i_m_stat);
        o_exc_w     = f_exc(i_W_stat);

        o_F_stall   = o_loaduse | o_retp;
        o_D_stall   = o_loaduse;
        // Load/use wins on D: the loading instruction's consumer is held
        // rather than squashed while a ret is also in flight.
        o_D_bubble  = o_misp | (!o_loaduse & o_retp);
        o_E_bubble  = o_misp | o_loaduse;
        // Keep memory side-effects out once any exception is in the tail.
        o_M_bubble  = o_exc_m | o_exc_w;
        o_W_stall   = o_exc_w;
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control unit for the five-stage Y86-64 core. Wraps
//               the combinational hazard detector with an IDLE/RUN/HALT
//               controller that gates core start and freezes the pipeline
//               once an exception status retires, plus optional performance
//               counters.
// Ports       : clk, rst_n (async active-low), start (one-cycle pulse)
//               D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode,
//               m_stat, W_stat                     - hazard inputs
//               F_stall, D_stall, W_stall          - hold stage registers
//               D_bubble, E_bubble, M_bubble       - inject nop
//               running, halted, final_stat        - controller status
//               cycle_cnt, lu_cnt, mp_cnt, ret_cnt - performance counters
// Config      : define PIPE_CTRL_PERF_EN to build the performance counters;
//               otherwise the counter outputs are constant zero.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int STAT_W = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_dstM,
    input  logic              e_Cnd,
    input  logic [3:0]        M_icode,
    input  logic [STAT_W-1:0] m_stat,
    input  logic [STAT_W-1:0] W_stat,
    output logic              F_stall,
    output logic              D_stall,
    output logic              W_stall,
    output logic              D_bubble,
    output logic              E_bubble,
    output logic              M_bubble,
    output logic              running,
    output logic              halted,
    output logic [STAT_W-1:0] final_stat,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  lu_cnt,
    output logic [CNT_W-1:0]  mp_cnt,
    output logic [CNT_W-1:0]  ret_cnt
);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic w_loaduse;
    logic w_retp;
    logic w_misp;
    logic w_exc_m;
    logic w_exc_w;
    logic w_F_stall_run;
    logic w_D_stall_run;
    logic w_W_stall_run;
    logic w_D_bubble_run;
    logic w_E_bubble_run;
    logic w_M_bubble_run;

    hazard_detect #(
        .STAT_W (STAT_W)
    ) u_hazard_detect (
        .i_D_icode  (D_icode),
        .i_d_srcA   (d_srcA),
        .i_d_srcB   (d_srcB),
        .i_E_icode  (E_icode),
        .i_E_dstM   (E_dstM),
        .i_e_Cnd    (e_Cnd),
        .i_M_icode  (M_icode),
        .i_m_stat   (m_stat),
        .i_W_stat   (W_stat),
        .o_loaduse  (w_loaduse),
        .o_retp     (w_retp),
        .o_misp     (w_misp),
        .o_exc_m    (w_exc_m),
        .o_exc_w    (w_exc_w),
        .o_F_stall  (w_F_stall_run),
        .o_D_stall  (w_D_stall_run),
        .o_W_stall  (w_W_stall_run),
        .o_D_bubble (w_D_bubble_run),
        .o_E_bubble (w_E_bubble_run),
        .o_M_bubble (w_M_bubble_run)
    );

    // ------------------------------------------------------------------
    // Run/halt controller
    // ------------------------------------------------------------------
    state_e              r_state;
    logic                r_armed;
    logic                r_running;
    logic                r_halted;
    logic [STAT_W-1:0]   r_final_stat;

    // r_armed is low for the first edge after reset release, so a start
    // pulse overlapping the reset-release cycle never launches the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_running    <= 1'b0;
            r_halted     <= 1'b0;
            r_final_stat <= STAT_W'(c_STAT_AOK);
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start && r_armed) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_exc_w) begin
                        r_state      <= S_HALT;
                        r_running    <= 1'b0;
                        r_halted     <= 1'b1;
                        r_final_stat <= W_stat;
                    end
                end
                S_HALT: begin
                    // Sticky until reset.
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign running    = r_running;
    assign halted     = r_halted;
    assign final_stat = r_final_stat;

    // ------------------------------------------------------------------
    // Stage control selection. The controls follow the state register
    // combinationally, so an asynchronous reset forces the IDLE hold
    // values without waiting for a clock.
    // ------------------------------------------------------------------
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        case (r_state)
            S_RUN: begin
                F_stall  = w_F_stall_run;
                D_stall  = w_D_stall_run;
                W_stall  = w_W_stall_run;
                D_bubble = w_D_bubble_run;
                E_bubble = w_E_bubble_run;
                M_bubble = w_M_bubble_run;
            end
            S_HALT: begin
                M_bubble = 1'b1;
            end
            default: begin
                // IDLE: hold fetch, decode and write-back.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_mp_cnt;
    logic [CNT_W-1:0] r_ret_cnt;
    logic             w_cnt_en;
    logic             w_unused_exc_m;

    assign w_cnt_en       = (r_state == S_RUN);
    assign w_unused_exc_m = w_exc_m;

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_lu_cnt    <= '0;
            r_mp_cnt    <= '0;
            r_ret_cnt   <= '0;
        end else if (w_cnt_en) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_loaduse) begin
                r_lu_cnt <= r_lu_cnt + CNT_W'(1);
            end
            if (w_misp) begin
                r_mp_cnt <= r_mp_cnt + CNT_W'(1);
            end
            // Ret cycles shadowed by a load/use stall are not counted.
            if (w_retp && !w_loaduse) begin
                r_ret_cnt <= r_ret_cnt + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign lu_cnt    = r_lu_cnt;
    assign mp_cnt    = r_mp_cnt;
    assign ret_cnt   = r_ret_cnt;
`else
    // The raw hazard terms only feed the counters.
    logic w_unused_terms;
    assign w_unused_terms = ^{w_loaduse, w_retp, w_misp, w_exc_m};

    assign cycle_cnt = '0;
    assign lu_cnt    = '0;
    assign mp_cnt    = '0;
    assign ret_cnt   = '0;
`endif

endmodule : pipe_ctrl
`default_nettype wire
